// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line levels.
// The line-level constants are also used by the receiving end.
package serial_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_tx_4bit_bit_timer.sv
// Modulo-BIT_CYCLES counter; tick marks the last cycle of each serial bit.
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int            TW = cnt_w(BIT_CYCLES);
  localparam logic [TW-1:0] TC = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt;

  assign tick = (cnt == TC);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + TW'(1);
  end
endmodule

// File: rtl/serial_tx_4bit.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first,
// stop bit, each held BIT_CYCLES cycles. All outputs decode registered state.
module serial_tx_4bit
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             txd,
  output logic             done
);
  localparam int            IW   = cnt_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  tx_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic             tick;
  logic             tmr_clr;

  // Timer held cleared while idle so the start bit always gets a full period.
  assign tmr_clr = (state == IDLE);

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          shreg <= d;
          idx   <= '0;
          state <= START;
        end
        START: if (tick) state <= DATA;
        DATA: if (tick) begin
          shreg <= shreg >> 1;
          if (idx == LAST) begin
            idx   <= '0;
            state <= STOP;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        STOP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    txd = IDLE_LEVEL;
    case (state)
      START:   txd = START_LEVEL;
      DATA:    txd = shreg[0];
      default: txd = IDLE_LEVEL;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;
  assign done  = (state == STOP) && tick;
endmodule

// File: doc/serial_tx_4bit.md
# serial_tx_4bit

Parallel-to-serial transmitter for the register datapath: accepts a WIDTH-bit word on a load strobe and shifts it out on a single line as a framed serial stream. The frame is start bit, data LSB first, then stop bit. It is the sending end of the serial link that the team's deserialising receiver consumes. It sits directly downstream of the load-enabled data register and takes its q output as d.

## Interface
- WIDTH, 4, data bits per frame (≥1)
- BIT_CYCLES, 1, clock cycles each serial bit is held on txd (≥1)

- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- load  input  1  request to send d; accepted only on a rising edge where ready=1 and rst=0
- d  input  WIDTH  word to transmit, sampled on the accepting edge only
- ready  output  1  high when idle and able to accept load
- busy  output  1  high while a frame is on the line (START, DATA, STOP)
- txd  output  1  serial line; idles high
- done  output  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1, ready=1, busy=0.
  - On load: capture d into the shift register, clear the bit timer and bit index, then go to START.
- START:
  - txd=0 for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - txd=shift[0] for BIT_CYCLES cycles per bit; shift right after each bit.
  - Bit index counts 0..WIDTH-1. After bit WIDTH-1 completes, go to STOP.
- STOP:
  - txd=1 for BIT_CYCLES cycles, then go to IDLE.
  - done=1 on the final STOP cycle only.
- load outside IDLE is ignored: no queueing, and d is not sampled.
- d changing after the accepting edge has no effect on the frame in flight.
- Bit timer width: max(1, $clog2(BIT_CYCLES)). Bit index width: max(1, $clog2(WIDTH)). Both wrap to 0 at terminal count, never past it.
- Reset values, applied on any edge with rst=1, including mid-frame:
  - state IDLE; txd=1, ready=1, busy=0, done=0.
  - Shift register, bit timer and bit index all 0.
  - A frame interrupted by reset is abandoned, not resumed.
- rst=1 and load=1 on the same edge: reset wins and the load is dropped.

## Timing
- Load accepted at edge T0: the start bit drives txd from T0+1.
- txd, ready, busy and done are all registered or decoded from registered state. No combinational path exists from load or d to any output.
- Frame length is (WIDTH+2)·BIT_CYCLES cycles; the default is 6.
- done is high in cycle T0+(WIDTH+2)·BIT_CYCLES. ready rises on the next edge.
- Back-to-back frames: a load presented the cycle ready returns is accepted. The minimum inter-frame gap is 1 idle cycle, with txd=1.
- busy = ~ready at all times after reset.

## Structure
- Shared package serial_tx_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, 2-bit encoding);
  - the IDLE_LEVEL=1 and START_LEVEL=0 constants, shared with the receiver.
- One sub-module, bit_timer: a BIT_CYCLES-modulo counter with clear input and a terminal-count output `tick`. The main FSM advances only on `tick`.
- Shift register and bit index live in serial_tx_4bit.

## Test plan
- Reset, then idle 5 cycles → txd=1, ready=1, busy=0, done=0 throughout.
- BIT_CYCLES=1, load d=5 → txd over cycles T0+1..T0+6 = 0,1,0,1,0,1; done pulses at T0+6; ready=1 at T0+7.
- BIT_CYCLES=1: load d=9 and accept, then hold load=1 with d=12 for the next 3 cycles.
  - Required: txd = 0,1,0,0,1,1.
  - The d=12 loads are ignored; exactly one done pulse.
- Back-to-back: load d=12, then reload on the first ready cycle.
  - Required: txd = 0,0,0,1,1,1, then one idle 1, then the second frame.
- BIT_CYCLES=3, d=4'hA → each bit held exactly 3 cycles: 000 000 111 000 111 111; frame length 18 cycles.
- rst=1 in the DATA state, with load=1 on the same edge → next cycle txd=1, ready=1, busy=0, no done pulse; the next legal load produces a clean full frame.
